// File: rtl/conv3x3_sched.sv
// conv3x3_sched: streams every (oc, ic) plane into the 3x3 line buffer and tags each window for the MAC.
module conv3x3_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 7,
  parameter int ADDR_WIDTH = 16,
  parameter int CH_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CH_WIDTH-1:0]   cfg_in_ch,
  input  logic [CH_WIDTH-1:0]   cfg_out_ch,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  lb_rst,
  output logic                  lb_valid_in,
  output logic [DATA_WIDTH-1:0] lb_data,
  input  logic                  lb_valid_out,
  output logic [ADDR_WIDTH-1:0] wgt_addr,
  output logic                  acc_first,
  output logic                  acc_last,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr
);
  localparam int PIX = WIDTH * WIDTH;
  localparam int WIN = (WIDTH - 2) * (WIDTH - 2);
  localparam int PW  = $clog2(PIX + 1);
  localparam int WW  = $clog2(WIN + 1);
  typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, NEXT, DONE} state_t;
  state_t state, state_nx;
  logic [CH_WIDTH-1:0] in_ch, out_ch, oc, ic;
  logic [PW-1:0] pix;
  logic [WW-1:0] win_cnt;
  logic last_ic, last_oc;
  assign last_ic = ic == in_ch - CH_WIDTH'(1);
  assign last_oc = oc == out_ch - CH_WIDTH'(1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (cfg_in_ch == '0 || cfg_out_ch == '0) ? DONE : CLR;
      CLR:     state_nx = STREAM;
      STREAM:  if (pix == PW'(PIX - 1)) state_nx = DRAIN;
      DRAIN:   if (win_cnt == WW'(WIN)) state_nx = NEXT;
      NEXT:    state_nx = (last_ic && last_oc) ? DONE : CLR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ch       <= '0;
      out_ch      <= '0;
      oc          <= '0;
      ic          <= '0;
      pix         <= '0;
      win_cnt     <= '0;
      lb_valid_in <= 1'b0;
    end else begin
      state       <= state_nx;
      lb_valid_in <= mem_rd_en;
      if (state == IDLE && start) begin
        in_ch  <= cfg_in_ch;
        out_ch <= cfg_out_ch;
        oc     <= '0;
        ic     <= '0;
      end
      if (state == CLR) begin
        pix     <= '0;
        win_cnt <= '0;
      end
      if (state == STREAM) pix <= pix + PW'(1);
      if (out_valid && win_cnt != WW'(WIN)) win_cnt <= win_cnt + WW'(1);
      if (state == NEXT) begin
        ic <= last_ic ? '0 : ic + CH_WIDTH'(1);
        if (last_ic && !last_oc) oc <= oc + CH_WIDTH'(1);
      end
    end
  end
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign mem_rd_en   = state == STREAM;
  assign mem_rd_addr = mem_rd_en ? ADDR_WIDTH'(ic) * ADDR_WIDTH'(PIX) + ADDR_WIDTH'(pix) : '0;
  assign lb_rst      = rst | (state == CLR);
  assign lb_data     = mem_rd_data;
  // ic/oc only move in NEXT, so these hold steady across every window of a plane
  assign wgt_addr    = busy ? ADDR_WIDTH'(oc) * ADDR_WIDTH'(in_ch) + ADDR_WIDTH'(ic) : '0;
  assign acc_first   = busy & (ic == '0);
  assign acc_last    = busy & last_ic;
  assign out_valid   = lb_valid_out & (state == STREAM || state == DRAIN);
  assign out_addr    = out_valid ? ADDR_WIDTH'(oc) * ADDR_WIDTH'(WIN) + ADDR_WIDTH'(win_cnt) : '0;
endmodule

// File: tb/tb_conv3x3_sched.sv
// tb_conv3x3_sched: scoreboard bench with memory and line-buffer models around conv3x3_sched.
module tb_conv3x3_sched;
  localparam int W = 7;
  localparam int PIX = W * W;
  localparam int WIN = (W - 2) * (W - 2);
  localparam int PLANE = PIX + 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [9:0] cfg_in_ch = '0, cfg_out_ch = '0;
  logic busy, done, mem_rd_en, lb_rst, lb_valid_in, lb_valid_out, acc_first, acc_last, out_valid;
  logic [15:0] mem_rd_addr, wgt_addr, out_addr;
  logic [31:0] mem_rd_data, lb_data;
  logic spur_mode = 1'b0, lbv_d, spur;
  int lb_cnt;
  int tests = 0, fails = 0, busy_cnt = 0, done_cnt = 0, rd_cnt = 0;
  typedef struct {logic [15:0] oa; logic [15:0] wa; logic f; logic l;} win_t;
  logic [15:0] rq[$];
  logic [31:0] dq[$];
  win_t wq[$];

  conv3x3_sched dut (
    .clk(clk), .rst(rst), .start(start), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .lb_rst(lb_rst), .lb_valid_in(lb_valid_in), .lb_data(lb_data),
    .lb_valid_out(lb_valid_out), .wgt_addr(wgt_addr), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? {16'hA5A5, mem_rd_addr} : '0;
    lbv_d <= lb_valid_in;
    if (lb_rst) lb_cnt <= 0;
    else if (lb_valid_in) lb_cnt <= lb_cnt + 1;
  end
  // injects spurious windows only in cycles with no pixel in flight (CLR, NEXT, DONE, IDLE)
  assign spur = spur_mode & ~mem_rd_en & ~lb_valid_in & ~lbv_d;
  assign lb_valid_out = (lb_valid_in && lb_cnt < PIX && lb_cnt / W >= 2 && lb_cnt % W >= 2) | spur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    win_t w;
    logic [15:0] a;
    if (!rst) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (mem_rd_en) begin
        rd_cnt++;
        chk("rd_expected", rq.size() > 0, 1);
        if (rq.size() > 0) begin
          a = rq.pop_front();
          chk("rd_addr", mem_rd_addr, a);
          dq.push_back({16'hA5A5, a});
        end
      end
      if (lb_valid_in) begin
        chk("lb_expected", dq.size() > 0, 1);
        if (dq.size() > 0) chk("lb_data", lb_data, dq.pop_front());
      end
      if (out_valid) begin
        chk("win_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("out_addr", out_addr, w.oa);
          chk("wgt_addr", wgt_addr, w.wa);
          chk("acc_first", acc_first, w.f);
          chk("acc_last", acc_last, w.l);
        end
      end
    end
  end

  task automatic push_layer(input int ci, input int co);
    for (int o = 0; o < co; o++)
      for (int i = 0; i < ci; i++) begin
        for (int p = 0; p < PIX; p++) rq.push_back(16'(i * PIX + p));
        for (int k = 0; k < WIN; k++) wq.push_back('{16'(o * WIN + k), 16'(o * ci + i), i == 0, i == ci - 1});
      end
  endtask

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; rd_cnt = 0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    @(negedge clk);
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic pulse_start(input int ci, input int co);
    @(posedge clk); #1;
    cfg_in_ch = 10'(ci); cfg_out_ch = 10'(co); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_in_ch = 10'h3FF; cfg_out_ch = 10'h3FF;
  endtask

  task automatic run_layer(input int ci, input int co);
    push_layer(ci, co);
    clear_counts();
    pulse_start(ci, co);
    wait_done(ci * co * PLANE + 20);
    @(negedge clk);
    chk("busy_cycles", busy_cnt, ci * co * PLANE + 1);
    chk("done_pulses", done_cnt, 1);
    chk("read_count", rd_cnt, ci * co * PIX);
    chk("rd_left", rq.size(), 0);
    chk("win_left", wq.size(), 0);
    chk("idle_after", {busy, done, mem_rd_en, out_valid}, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {busy, done, mem_rd_en, lb_rst, lb_valid_in, out_valid, acc_first, acc_last}, 0);
    chk({tag, "_rd_addr"}, mem_rd_addr, 0);
    chk({tag, "_wgt_addr"}, wgt_addr, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lb_rst_in_reset", lb_rst, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_lb_data", lb_data, 0);

    run_layer(1, 1);
    run_layer(2, 2);
    run_layer(0, 3);

    push_layer(2, 2);
    clear_counts();
    pulse_start(2, 2);
    n = 0;
    while (rd_cnt < PIX + 9 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reads_before_rst", rd_cnt, PIX + 9);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("lb_rst_mid", lb_rst, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("mid_rst");
    chk("no_done_on_rst", done_cnt, 0);
    rq.delete(); dq.delete(); wq.delete();
    run_layer(1, 1);

    push_layer(2, 1);
    push_layer(1, 1);
    clear_counts();
    @(posedge clk); #1;
    cfg_in_ch = 10'd2; cfg_out_ch = 10'd1; start = 1'b1;
    repeat (60) @(posedge clk);
    #1 cfg_in_ch = 10'd1;
    wait_done(200);
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0;
    wait_done(100);
    @(negedge clk);
    chk("held_busy", busy_cnt, 2 * PLANE + 1 + PLANE + 1);
    chk("held_done", done_cnt, 2);
    chk("held_reads", rd_cnt, 3 * PIX);
    chk("held_rd_left", rq.size(), 0);
    chk("held_win_left", wq.size(), 0);
    chk("held_idle", busy, 0);

    spur_mode = 1'b1;
    run_layer(1, 2);
    spur_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
